// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage register: state encoding, mode
// selectors and the MEM/WB payload layout used by wrappers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int MODE_SKID = 0;
  localparam int MODE_REG  = 1;

  // MEM/WB bundle, MSB first: MemtoReg, RegWrite, MemDout, ALUResult, rdAddr
  localparam int MEMWB_W            = 71;
  localparam int MEMWB_RD_LSB       = 0;
  localparam int MEMWB_RD_W         = 5;
  localparam int MEMWB_ALU_LSB      = 5;
  localparam int MEMWB_DOUT_LSB     = 37;
  localparam int MEMWB_WORD_W       = 32;
  localparam int MEMWB_REGWRITE_BIT = 69;
  localparam int MEMWB_MEMTOREG_BIT = 70;

  function automatic logic [MEMWB_W-1:0] pack_memwb(
    input logic        mem_to_reg,
    input logic        reg_write,
    input logic [31:0] mem_dout,
    input logic [31:0] alu_result,
    input logic [4:0]  rd_addr
  );
    return {mem_to_reg, reg_write, mem_dout, alu_result, rd_addr};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register: 2-entry skid buffer (registered
// in_ready) or single register (combinational in_ready), with flush.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 71,
  parameter int MODE           = 0,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              r,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  generate
    if (MODE == MODE_SKID) begin : g_skid
      state_e            state_q;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic              in_ready_q;

      // in_ready_q always mirrors (next state != ST_TWO)
      always_ff @(posedge clk or negedge r) begin
        if (!r) begin
          state_q    <= ST_EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else if (flush) begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
          if (CLEAR_ON_FLUSH != 0) begin
            main_q <= '0;
            skid_q <= '0;
          end
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire) begin
                state_q <= ST_ONE;
                main_q  <= in_data;
              end
            end
            ST_ONE: begin
              if (in_fire && out_fire) begin
                main_q <= in_data;
              end else if (in_fire) begin
                state_q    <= ST_TWO;
                skid_q     <= in_data;
                in_ready_q <= 1'b0;
              end else if (out_fire) begin
                state_q <= ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (out_fire) begin
                state_q    <= ST_ONE;
                main_q     <= skid_q;
                in_ready_q <= 1'b1;
              end
            end
            default: begin
              state_q    <= ST_EMPTY;
              in_ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != ST_EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
    end else begin : g_reg
      logic              valid_q;
      logic [DATA_W-1:0] main_q;

      always_ff @(posedge clk or negedge r) begin
        if (!r) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
          if (CLEAR_ON_FLUSH != 0) begin
            main_q <= '0;
          end
        end else if (in_fire) begin
          valid_q <= 1'b1;
          main_q  <= in_data;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .r    (r),
    .inc  (out_valid & ~out_ready),
    .clr  (stall_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a skid-mode and a register-mode stage with shared stimulus and checks
// both against a FIFO-capacity reference model.
module tb_pipe_stage_skid;

  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          r = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;

  logic          ir0, ov0, ir1, ov1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    oc0, oc1;
  logic [CW-1:0] sc0, sc1;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .MODE(0), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut0 (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0), .stall_cnt(sc0), .stall_clr(stall_clr)
  );

  pipe_stage_skid #(.DATA_W(DW), .MODE(1), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut1 (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1), .stall_cnt(sc1), .stall_clr(stall_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 = capacity-2 FIFO, index 1 = capacity-1 FIFO
  int            occ  [2];
  logic [DW-1:0] ent  [2][2];
  logic [DW-1:0] last [2];
  int            scnt [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_rdy(input int d);
    if (d == 0) return occ[0] < 2;
    return (occ[1] == 0) || out_ready;
  endfunction

  function automatic logic [DW-1:0] model_data(input int d);
    return (occ[d] > 0) ? ent[d][0] : last[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      occ[d]  = 0;
      last[d] = '0;
      scnt[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit rdy, inf, outf;
    rdy  = model_rdy(d);
    inf  = in_valid && rdy && !flush;
    outf = (occ[d] > 0) && out_ready;
    if (stall_clr) scnt[d] = 0;
    else if ((occ[d] > 0) && !out_ready && (scnt[d] < SAT)) scnt[d]++;
    if (outf) begin
      $display("dut%0d delivered 0x%0h", d, ent[d][0]);
      last[d]   = ent[d][0];
      ent[d][0] = ent[d][1];
      occ[d]--;
    end
    if (inf) begin
      ent[d][occ[d]] = in_data;
      occ[d]++;
    end
    if (flush) begin
      occ[d]  = 0;
      last[d] = '0;
    end
  endtask

  task automatic check_ready();
    check_eq("dut0_in_ready", 32'(ir0), 32'(model_rdy(0)));
    check_eq("dut1_in_ready", 32'(ir1), 32'(model_rdy(1)));
  endtask

  task automatic check_outputs();
    check_eq("dut0_out_valid", 32'(ov0), 32'(occ[0] > 0));
    check_eq("dut0_out_data",  32'(od0), 32'(model_data(0)));
    check_eq("dut0_occupancy", 32'(oc0), 32'(occ[0]));
    check_eq("dut0_stall_cnt", 32'(sc0), 32'(scnt[0]));
    check_eq("dut1_out_valid", 32'(ov1), 32'(occ[1] > 0));
    check_eq("dut1_out_data",  32'(od1), 32'(model_data(1)));
    check_eq("dut1_occupancy", 32'(oc1), 32'(occ[1]));
    check_eq("dut1_stall_cnt", 32'(sc1), 32'(scnt[1]));
  endtask

  // One clock cycle: drive at the falling edge, check ready, advance, check outputs
  task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy,
                      input bit fl, input bit clr);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    #1;
    check_ready();
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    #2;
    r = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_ready();
    @(posedge clk);
    #2;
    r = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    r = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    check_ready();
    r = 1'b1;

    // Stream of four back-to-back entries
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure then drain
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full, with a same-cycle input that must be dropped
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Single-register stall then same-cycle replace
    step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall counter saturation and clear
    step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("dut0_stall_saturated", 32'(sc0), 32'(SAT));
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while the skid buffer is full
    step(1'b1, 16'h0041, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset();
      step($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
